imem_loader: RTL and testbench
==============================

# imem_loader

Program loader that fills the instruction memory read by `alu_branch`. It accepts an 8-bit byte stream over a valid/ready handshake and packs every four bytes into one 32-bit big-endian instruction word. Each word is written to consecutive 9-bit instruction addresses starting at 0. The loader holds the core in reset until a complete program has been written.

## Interface
Parameters:
- `ADDR_W`, 9: instruction address width; matches `alu_branch` pc.
- `DATA_W`, 32: instruction word width.
- `DEPTH`, 512: instruction memory depth in words; equals 2^ADDR_W.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse that begins a load.
- `in_valid`  in  1  byte on `in_data` is valid.
- `in_data`  in  8  program byte.
- `in_last`  in  1  qualifies the final byte of the program; sampled only with a handshake.
- `in_ready`  out  1  loader can accept a byte this cycle.
- `wr_en`  out  1  instruction memory write strobe.
- `wr_addr`  out  ADDR_W  write address.
- `wr_data`  out  DATA_W  write data.
- `core_reset`  out  1  holds `alu_branch` in reset.
- `done`  out  1  program loaded; core released.
- `error`  out  1  malformed or oversized program.
- `word_count`  out  ADDR_W+1  number of words written in the current load.

## Operation
- FSM states: IDLE, LOAD, WRITE, DONE, ERR.
- IDLE:
  - `in_ready`=0; `in_valid` is ignored.
  - `start` moves to LOAD and clears the address, byte index, packing register and `word_count`.
- LOAD:
  - `in_ready`=1. A byte is accepted when `in_valid`&&`in_ready`.
  - Byte index 0..3 selects the destination: index 0 goes to bits 31:24 and index 3 goes to bits 7:0.
  - Acceptance of the byte at index 3 moves to WRITE.
  - `in_last` on an accepted byte whose index is not 3 moves to ERR; that partial word is not written.
- WRITE (one cycle):
  - `wr_en`=1, `wr_addr`=current address, `wr_data`=packed word, `in_ready`=0.
  - Address increments and `word_count` increments.
  - Next state is DONE if the index-3 byte carried `in_last`.
  - Otherwise, if the address just written was DEPTH-1, next state is ERR (program too large).
  - Otherwise, next state is LOAD.
- DONE: `done`=1, `core_reset`=0, `in_ready`=0. `start` restarts a load from address 0 and moves to LOAD.
- ERR: `error`=1, `core_reset`=1, `in_ready`=0. `start` clears `error` and moves to LOAD.
- `start` while in LOAD or WRITE is ignored.
- `core_reset`=1 in every state except DONE.
- Memory contents are never cleared by the loader. Words beyond the new program length keep their old values.

## Timing
- Reset values: `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `core_reset`=1, `done`=0, `error`=0, `word_count`=0. State is IDLE.
- `reset` mid-load returns to IDLE on the next edge. Words already written stay in memory; the partial word is discarded.
- `start` seen at edge N gives `in_ready`=1 in cycle N+1.
- Write timing: the fourth byte is accepted at edge N, `wr_en` is high for exactly cycle N+1, and `in_ready` is high again in cycle N+2.
- Peak throughput is 4 bytes per 5 cycles.
- `done` rises in the cycle after the final write, and `core_reset` falls in the same cycle.
- `wr_addr`/`wr_data` hold their last written values when `wr_en`=0.
- `word_count` saturates at DEPTH (512). It never wraps, and `wr_addr` never wraps past DEPTH-1.

## Structure
- Shared package holds:
  - `ADDR_W`, `DATA_W`, `DEPTH`, shared with `alu_branch` and the instruction memory.
  - FSM state encoding constants for IDLE/LOAD/WRITE/DONE/ERR.
- One sub-module, `imem_byte_packer`:
  - 2-bit byte index and 32-bit shift/assembly register.
  - Ports: accept strobe, byte in, word out, word-complete flag, and a clear input.
- FSM, address counter and `word_count` live in the top module.

## Test plan
- Reset then `start`; bytes 00 00 00 13, 00 10 00 93 with `in_last` on the 8th byte. Required: writes (0, 0x00000013) and (1, 0x00100093); `done`=1 and `core_reset`=0 one cycle after the second write; `word_count`=2.
- Same stream with `in_valid` toggled every other cycle. Required: identical writes; no byte lost or duplicated; `in_ready`=0 during each WRITE cycle.
- Six bytes with `in_last` on byte 6. Required: one write (addr 0); `error`=1; `core_reset`=1; no write for addr 1.
- 2048 bytes with no `in_last`. Required: writes to addr 0..511; ERR entered after the addr-511 write; `word_count`=512; no write to addr 0 again.
- `reset` asserted after 2 bytes of word 3 (addr 2). Required: IDLE with all outputs at reset values. A following `start` plus a 4-byte program with `in_last` writes addr 0 only, then `done`=1.
- `start` pulsed in LOAD mid-word, then pulsed again in DONE. Required: the first pulse has no effect; the second gives `done`=0, `core_reset`=1, `word_count`=0, and the next write goes to addr 0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared instruction-memory geometry and loader FSM encoding, common to
// imem_loader, alu_branch and the instruction memory.
package imem_loader_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 512;

  localparam int BYTES_PER_WORD = DATA_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_WRITE = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } load_state_t;

endpackage

// File: rtl/imem_byte_packer.sv
// Packs accepted bytes big-endian into a 32-bit word; the first byte of a
// word lands in bits 31:24, the fourth in bits 7:0.
module imem_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  input  logic [7:0]        byte_in,
  output logic [DATA_W-1:0] word_out,
  output logic              word_complete
);

  logic [1:0]        byte_idx;
  logic [DATA_W-1:0] word_q;

  // Shifting left means four accepts fully replace the previous word.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      byte_idx <= 2'd0;
      word_q   <= '0;
    end else if (accept) begin
      byte_idx <= byte_idx + 2'd1;
      word_q   <= {word_q[DATA_W-9:0], byte_in};
    end
  end

  assign word_complete = accept && (byte_idx == 2'd3);
  assign word_out      = word_q;

endmodule

// File: rtl/imem_loader.sv
// Program loader: streams bytes into 32-bit instruction words, writes them
// to consecutive addresses and holds the core in reset until loading ends.
module imem_loader #(
  parameter int ADDR_W = imem_loader_pkg::ADDR_W,
  parameter int DATA_W = imem_loader_pkg::DATA_W,
  parameter int DEPTH  = imem_loader_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              core_reset,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   word_count
);

  import imem_loader_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   MAX_COUNT = (ADDR_W + 1)'(DEPTH);

  load_state_t       state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   count;
  logic              last_q;
  logic [ADDR_W-1:0] addr_hold;
  logic [DATA_W-1:0] data_hold;
  logic              accept;
  logic              load_start;
  logic              word_complete;
  logic [DATA_W-1:0] packed_word;

  assign in_ready = (state == ST_LOAD);
  assign accept   = in_valid && in_ready;

  imem_byte_packer u_packer (
    .clk           (clk),
    .reset         (reset),
    .clear         (load_start),
    .accept        (accept),
    .byte_in       (in_data),
    .word_out      (packed_word),
    .word_complete (word_complete)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // A last flag on a byte that does not close a word aborts without writing.
  always_comb begin
    state_nxt  = state;
    load_start = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_nxt  = ST_LOAD;
          load_start = 1'b1;
        end
      end
      ST_LOAD: begin
        if (word_complete) begin
          state_nxt = ST_WRITE;
        end else if (accept && in_last) begin
          state_nxt = ST_ERR;
        end
      end
      ST_WRITE: begin
        if (last_q) begin
          state_nxt = ST_DONE;
        end else if (addr == LAST_ADDR) begin
          state_nxt = ST_ERR;
        end else begin
          state_nxt = ST_LOAD;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Address and count saturate so an oversized program cannot wrap onto word 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr      <= '0;
      count     <= '0;
      last_q    <= 1'b0;
      addr_hold <= '0;
      data_hold <= '0;
    end else begin
      if (load_start) begin
        addr   <= '0;
        count  <= '0;
        last_q <= 1'b0;
      end
      if (word_complete) begin
        last_q <= in_last;
      end
      if (state == ST_WRITE) begin
        addr_hold <= addr;
        data_hold <= packed_word;
        if (addr != LAST_ADDR) begin
          addr <= addr + 1'b1;
        end
        if (count < MAX_COUNT) begin
          count <= count + 1'b1;
        end
      end
    end
  end

  assign wr_en      = (state == ST_WRITE);
  assign wr_addr    = wr_en ? addr : addr_hold;
  assign wr_data    = wr_en ? packed_word : data_hold;
  assign done       = (state == ST_DONE);
  assign error      = (state == ST_ERR);
  assign core_reset = !done;
  assign word_count = count;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: drives byte programs with varied valid
// gaps and compares observed writes and status against a word-level model.
module tb_imem_loader;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 512;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_last;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              core_reset;
  logic              done;
  logic              error;
  logic [ADDR_W:0]   word_count;

  int total = 0;
  int bad   = 0;

  logic [7:0]  prog [0:2047];
  logic [40:0] wr_q [$];
  logic [40:0] exp_q [$];
  bit          exp_err;
  int          exp_words;
  bit          prev_wr;
  bit          prev_done;

  imem_loader dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .core_reset (core_reset),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Write collector; also checks handshake is closed during writes and that
  // done only rises directly after a write.
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_en) begin
        wr_q.push_back({wr_addr, wr_data});
        checkOutput("ready_in_write", in_ready, 0);
      end
      if (done && !prev_done) checkOutput("done_after_write", prev_wr, 1);
      prev_wr   = wr_en;
      prev_done = done;
    end else begin
      prev_wr   = 1'b0;
      prev_done = 1'b0;
    end
  end

  // Model: only whole words up to the last byte are written, capped at DEPTH.
  task automatic build_expected(input int n, input int last_pos);
    int nbytes;
    int nw;
    logic [8:0] a;
    exp_q.delete();
    nbytes = (last_pos >= 0) ? last_pos + 1 : n;
    nw = nbytes / 4;
    if (nw > DEPTH) nw = DEPTH;
    exp_err   = (last_pos < 0) || (nbytes % 4 != 0);
    exp_words = nw;
    for (int i = 0; i < nw; i++) begin
      a = i[8:0];
      exp_q.push_back({a, prog[4*i], prog[4*i+1], prog[4*i+2], prog[4*i+3]});
    end
  endtask

  task automatic compare_writes();
    int n;
    checkOutput("nwrites", wr_q.size(), exp_q.size());
    n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("wr_addr[%0d]", i), wr_q[i][40:32], exp_q[i][40:32]);
      checkOutput($sformatf("wr_data[%0d]", i), wr_q[i][31:0], exp_q[i][31:0]);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_start", in_ready, 1);
    checkOutput("done_after_start", done, 0);
    checkOutput("error_after_start", error, 0);
    checkOutput("core_reset_after_start", core_reset, 1);
    checkOutput("count_after_start", word_count, 0);
    @(posedge clk);
    #1;
  endtask

  // mode 0: always valid, 1: valid every other cycle, 2: random valid.
  task automatic applyStimulus(input int first, input int count, input int last_pos, input int mode);
    int idx = 0;
    int cyc = 0;
    int pos;
    bit pend = 0;
    while (idx < count) begin
      if (cyc > count * 8 + 100) begin
        checkOutput("drive_timeout", 0, 1);
        break;
      end
      pos = first + idx;
      case (mode)
        0:       in_valid = 1'b1;
        1:       in_valid = cyc[0];
        default: in_valid = 1'($urandom_range(0, 1));
      endcase
      in_data = in_valid ? prog[pos] : 8'($urandom);
      in_last = in_valid && (pos == last_pos);
      @(negedge clk);
      if (pend) begin
        checkOutput("wr_en_after_byte3", wr_en, 1);
        pend = 0;
      end
      if (in_valid && in_ready) begin
        if (pos % 4 == 3) pend = 1;
        idx++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (pend) begin
      @(negedge clk);
      checkOutput("wr_en_after_byte3", wr_en, 1);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_end();
    int k = 0;
    @(negedge clk);
    while (!(done || error) && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (k >= 40) checkOutput("end_timeout", 0, 1);
    checkOutput("done", done, !exp_err);
    checkOutput("error", error, exp_err);
    checkOutput("core_reset", core_reset, exp_err);
    checkOutput("word_count", word_count, exp_words);
    compare_writes();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_prog(input int n);
    for (int i = 0; i < n; i++) prog[i] = 8'($urandom);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 0);
    checkOutput("rst_wr_en", wr_en, 0);
    checkOutput("rst_wr_addr", wr_addr, 0);
    checkOutput("rst_wr_data", wr_data, 0);
    checkOutput("rst_core_reset", core_reset, 1);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_error", error, 0);
    checkOutput("rst_word_count", word_count, 0);

    $display("[TB] fixed 8-byte program");
    prog[0] = 8'h00; prog[1] = 8'h00; prog[2] = 8'h00; prog[3] = 8'h13;
    prog[4] = 8'h00; prog[5] = 8'h10; prog[6] = 8'h00; prog[7] = 8'h93;
    wr_q.delete();
    pulse_start();
    applyStimulus(0, 8, 7, 0);
    build_expected(8, 7);
    wait_end();

    $display("[TB] same program, toggling valid");
    wr_q.delete();
    pulse_start();
    applyStimulus(0, 8, 7, 1);
    wait_end();

    $display("[TB] six bytes, last on byte 6");
    randomize_prog(6);
    wr_q.delete();
    pulse_start();
    applyStimulus(0, 6, 5, 2);
    build_expected(6, 5);
    wait_end();

    $display("[TB] 2048 bytes without last");
    randomize_prog(2048);
    wr_q.delete();
    pulse_start();
    applyStimulus(0, 2048, -1, 0);
    build_expected(2048, -1);
    wait_end();

    $display("[TB] reset in the middle of word 3");
    randomize_prog(10);
    wr_q.delete();
    pulse_start();
    applyStimulus(0, 10, -1, 2);
    build_expected(8, -1);
    compare_writes();
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_in_ready", in_ready, 0);
    checkOutput("mid_rst_wr_en", wr_en, 0);
    checkOutput("mid_rst_wr_addr", wr_addr, 0);
    checkOutput("mid_rst_wr_data", wr_data, 0);
    checkOutput("mid_rst_core_reset", core_reset, 1);
    checkOutput("mid_rst_done", done, 0);
    checkOutput("mid_rst_error", error, 0);
    checkOutput("mid_rst_word_count", word_count, 0);
    randomize_prog(4);
    wr_q.delete();
    pulse_start();
    applyStimulus(0, 4, 3, 2);
    build_expected(4, 3);
    wait_end();

    $display("[TB] start pulses in LOAD and DONE");
    randomize_prog(8);
    wr_q.delete();
    pulse_start();
    applyStimulus(0, 2, 7, 0);
    pulse_start();
    applyStimulus(2, 6, 7, 2);
    build_expected(8, 7);
    wait_end();
    randomize_prog(4);
    wr_q.delete();
    pulse_start();
    applyStimulus(0, 4, 3, 2);
    build_expected(4, 3);
    wait_end();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
